// File: rtl/multi_dataflow_out_tracker_pkg.sv
// Shared definitions for the outStream0 output tracker.
// - ot_state_e : tracker FSM states.
// - ot_flags_t : count/done/idle flags, sized for the default job length, so the
//                engine can embed them in its own flags structure.
package multi_dataflow_out_tracker_pkg;

   localparam int unsigned OT_CNT_LEN = 1024;
   localparam int unsigned OT_CW      = $clog2(OT_CNT_LEN) + 1;

   typedef enum logic [1:0] {
      OT_IDLE,
      OT_RUN,
      OT_DRAIN,
      OT_DONE
   } ot_state_e;

   typedef struct packed {
      logic [OT_CW-1:0] cnt;
      logic             done;
      logic             idle;
   } ot_flags_t;

endpackage

// File: rtl/multi_dataflow_out_tracker_if.sv
// Stream bundle between the kernel output, the tracker and the TCDM sink.
// - in_valid_i/in_data_i/in_ready_o        : kernel -> tracker beat handshake.
// - out_valid_o/out_data_o/out_strb_o/out_ready_i : tracker -> sink beat handshake.
// Modports: slave = tracker side, master = kernel/sink (environment) side.
interface multi_dataflow_out_tracker_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                    in_valid_i;
   logic [DATA_WIDTH-1:0]   in_data_i;
   logic                    in_ready_o;
   logic                    out_valid_o;
   logic [DATA_WIDTH-1:0]   out_data_o;
   logic [DATA_WIDTH/8-1:0] out_strb_o;
   logic                    out_ready_i;

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_strb_o
   );

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_strb_o
   );

endinterface

// File: rtl/multi_dataflow_skid2.sv
// 2-entry FIFO used as the tracker's elastic buffer.
// - clk   : clock, rising edge.
// - flush : synchronous flush, empties the buffer and zeroes storage.
// - push/push_data : write one entry (caller guarantees not full).
// - pop   : drop the head entry (caller guarantees not empty).
// - head  : current head entry, registered storage only.
// - occ   : registered occupancy, 0..2.
module multi_dataflow_skid2 #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            occ
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            occ_q;

   always_ff @(posedge clk) begin
      if (flush) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         // Simultaneous push and pop leaves occupancy unchanged.
         unique case ({push, pop})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head = mem_q[rd_ptr_q];
   assign occ  = occ_q;

endmodule

// File: rtl/multi_dataflow_out_tracker.sv
// Output tracker between the multi_dataflow kernel and the outStream0 sink.
// Buffers beats in a 2-entry FIFO, counts beats delivered to the sink and
// ends the job with a one-cycle done pulse once the programmed limit is reached.
// - clk_i, rst_i (sync, active-high), clear_i (sync flush, same as reset).
// - enable_i    : gates input acceptance only.
// - start_i, cnt_limit_i : job start (IDLE only) and beat limit, clamped to CNT_LEN.
// - stream      : kernel input and sink output handshakes (slave modport).
// - cnt_o       : beats delivered in the current job, held until next start.
// - done_o      : one-cycle pulse at job end; idle_o : high in IDLE.
module multi_dataflow_out_tracker
   import multi_dataflow_out_tracker_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned CNT_LEN    = 1024,
   localparam int unsigned CW         = $clog2(CNT_LEN) + 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         enable_i,
   input  logic                         start_i,
   input  logic [CW-1:0]                cnt_limit_i,
   multi_dataflow_out_tracker_if.slave  stream,
   output logic [CW-1:0]                cnt_o,
   output logic                         done_o,
   output logic                         idle_o
);

   ot_state_e             state_q, state_d;
   logic [CW-1:0]         limit_q;
   logic [CW-1:0]         in_cnt_q;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         limit_clamped;
   logic [DATA_WIDTH-1:0] head;
   logic [1:0]            occ;
   logic                  flush;
   logic                  push;
   logic                  pop;
   logic                  start_ok;

   assign flush         = rst_i | clear_i;
   assign start_ok      = (state_q == OT_IDLE) & start_i;
   assign limit_clamped = (cnt_limit_i > CW'(CNT_LEN)) ? CW'(CNT_LEN) : cnt_limit_i;

   // Acceptance uses registered occupancy only, so sink back-pressure never
   // reaches in_ready_o combinationally.
   assign stream.in_ready_o = (state_q == OT_RUN) & enable_i & (occ != 2'd2) &
                              (in_cnt_q < limit_q);

   assign push = stream.in_valid_i & stream.in_ready_o;
   assign pop  = stream.out_valid_o & stream.out_ready_i;

   multi_dataflow_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid2 (
      .clk       (clk_i),
      .flush     (flush),
      .push      (push),
      .push_data (stream.in_data_i),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   assign stream.out_valid_o = (occ != 2'd0);
   assign stream.out_data_o  = head;
   assign stream.out_strb_o  = {(DATA_WIDTH/8){stream.out_valid_o}};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OT_IDLE: begin
            if (start_i) begin
               state_d = (cnt_limit_i == '0) ? OT_DONE : OT_RUN;
            end
         end
         OT_RUN: begin
            if (in_cnt_q == limit_q) begin
               state_d = OT_DRAIN;
            end
         end
         OT_DRAIN: begin
            if ((occ == 2'd0) && (cnt_q == limit_q)) begin
               state_d = OT_DONE;
            end
         end
         OT_DONE: state_d = OT_IDLE;
         default: state_d = OT_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (flush) begin
         state_q  <= OT_IDLE;
         limit_q  <= '0;
         in_cnt_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            limit_q  <= limit_clamped;
            in_cnt_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push) begin
               in_cnt_q <= in_cnt_q + CW'(1);
            end
            if (pop) begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = (state_q == OT_DONE);
   assign idle_o = (state_q == OT_IDLE);

endmodule
